// File: rtl/uart2axis_pkt_ctrl.sv
// UART byte stream to AXI-Stream packet controller: 2-byte word-count header, MSB-first word packing, word FIFO.
// Optional inter-byte timeout enabled by defining UART_PKT_TIMEOUT_EN.
module uart2axis_pkt_ctrl #(
  parameter int unsigned OUT_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        pi_clk,
  input  logic        pi_rst,
  input  logic [7:0]  pi_rx_data,
  input  logic        pi_rx_valid,
  output logic [31:0] po_tdata,
  output logic        po_tvalid,
  input  logic        pi_tready,
  output logic        po_tlast,
  output logic        po_busy,
  output logic        po_overflow,
  output logic        po_timeout
);

  localparam int unsigned AW = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEN_HI,
    S_PAYLOAD
  } state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] words_left;
  logic [1:0]  byte_idx;
  logic [23:0] shreg;

  logic [32:0]   mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        wr_en;
  logic [31:0] push_data;
  logic        push_last;
  logic        tmo_fire;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);

  logic [GW-1:0] gap_cnt;
  logic [31:0]   tmo_word;

  always_ff @(posedge pi_clk) begin
    if (pi_rst || pi_rx_valid || state == S_IDLE) begin
      gap_cnt <= '0;
    end else if (!tmo_fire) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // gap_cnt holds the silent edges already seen, so this edge is the TIMEOUT_CYCLES-th
  assign tmo_fire = (state != S_IDLE) && !pi_rx_valid &&
                    (gap_cnt == GW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_word = '0;
    case (byte_idx)
      2'd1:    tmo_word = {shreg[7:0], 24'h0};
      2'd2:    tmo_word = {shreg[15:0], 16'h0};
      2'd3:    tmo_word = {shreg, 8'h0};
      default: tmo_word = '0;
    endcase
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    push      = 1'b0;
    push_data = {shreg, pi_rx_data};
    push_last = (words_left == 16'd1);
    if (state == S_PAYLOAD && pi_rx_valid && byte_idx == 2'd3) begin
      push = 1'b1;
    end
`ifdef UART_PKT_TIMEOUT_EN
    if (state == S_PAYLOAD && tmo_fire) begin
      push      = 1'b1;
      push_data = tmo_word;
      push_last = 1'b1;
    end
`endif
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(OUT_DEPTH));
  assign pop   = !empty && pi_tready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      po_timeout <= 1'b0;
    end else begin
      po_timeout <= tmo_fire;
      case (state)
        S_IDLE: begin
          if (pi_rx_valid) begin
            len_lo <= pi_rx_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (pi_rx_valid) begin
            if ({pi_rx_data, len_lo} == 16'd0) begin
              state <= S_IDLE;
            end else begin
              words_left <= {pi_rx_data, len_lo};
              byte_idx   <= '0;
              state      <= S_PAYLOAD;
            end
          end else if (tmo_fire) begin
            state <= S_IDLE;
          end
        end
        S_PAYLOAD: begin
          if (pi_rx_valid) begin
            shreg    <= {shreg[15:0], pi_rx_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) state <= S_IDLE;
            end
          end else if (tmo_fire) begin
            byte_idx <= '0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      po_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      count <= count + 1'b1;
      else if (!wr_en && pop) count <= count - 1'b1;
      if (push && full && !pop) po_overflow <= 1'b1;
    end
  end

  always_ff @(posedge pi_clk) begin
    if (wr_en) mem[wr_ptr] <= {push_last, push_data};
  end

  // head is masked while empty so stale entries never show after reset
  assign po_tvalid = !empty;
  assign po_tdata  = empty ? '0 : mem[rd_ptr][31:0];
  assign po_tlast  = !empty && mem[rd_ptr][32];
  assign po_busy   = (state != S_IDLE);

endmodule

// File: tb/tb_uart2axis_pkt_ctrl.sv
// Directed bench for uart2axis_pkt_ctrl with OUT_DEPTH=4 and TIMEOUT_CYCLES=50.
module tb_uart2axis_pkt_ctrl;

  logic        pi_clk = 1'b0;
  logic        pi_rst;
  logic [7:0]  pi_rx_data;
  logic        pi_rx_valid;
  logic [31:0] po_tdata;
  logic        po_tvalid;
  logic        pi_tready;
  logic        po_tlast;
  logic        po_busy;
  logic        po_overflow;
  logic        po_timeout;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  logic [32:0] beats[$];
  logic        hold_prev = 1'b0;
  logic [32:0] held = '0;

  always #5 pi_clk = ~pi_clk;

  uart2axis_pkt_ctrl #(
    .OUT_DEPTH(4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .pi_clk(pi_clk),
    .pi_rst(pi_rst),
    .pi_rx_data(pi_rx_data),
    .pi_rx_valid(pi_rx_valid),
    .po_tdata(po_tdata),
    .po_tvalid(po_tvalid),
    .pi_tready(pi_tready),
    .po_tlast(po_tlast),
    .po_busy(po_busy),
    .po_overflow(po_overflow),
    .po_timeout(po_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int unsigned idx, input logic [32:0] exp);
    logic [63:0] none;
    none = 'x;
    if (idx < beats.size()) chk(tag, 64'(beats[idx]), 64'(exp));
    else chk(tag, none, 64'(exp));
  endtask

  // beats are taken just before the edge that completes the handshake
  always @(negedge pi_clk) begin
    #1;
    if (!pi_rst && po_tvalid && pi_tready) beats.push_back({po_tlast, po_tdata});
    if (hold_prev && po_tvalid && !pi_rst) chk("hold_stable", 64'({po_tlast, po_tdata}), 64'(held));
    hold_prev = po_tvalid && !pi_tready && !pi_rst;
    held = {po_tlast, po_tdata};
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge pi_clk);
    pi_rx_data  = b;
    pi_rx_valid = 1'b1;
    @(negedge pi_clk);
    pi_rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge pi_clk);
  endtask

  task automatic do_reset();
    @(negedge pi_clk);
    pi_rst = 1'b1;
    @(negedge pi_clk);
    pi_rst = 1'b0;
  endtask

  initial begin
    pi_rst      = 1'b1;
    pi_rx_data  = '0;
    pi_rx_valid = 1'b0;
    pi_tready   = 1'b0;
    idle(3);
    pi_rst = 1'b0;

    // reset state
    chk("rst_tvalid", po_tvalid, 1'b0);
    chk("rst_tdata", po_tdata, 32'h0);
    chk("rst_tlast", po_tlast, 1'b0);
    chk("rst_busy", po_busy, 1'b0);
    chk("rst_overflow", po_overflow, 1'b0);
    chk("rst_timeout", po_timeout, 1'b0);

    // two-word packet, sink always ready
    beats.delete();
    pi_tready = 1'b1;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
    chk("t2_busy_mid", po_busy, 1'b1);
    send_byte(8'h88);
    chk("t2_busy_end", po_busy, 1'b0);
    idle(4);
    chk("t2_nbeats", beats.size(), 2);
    chk_beat("t2_beat0", 0, {1'b0, 32'h11223344});
    chk_beat("t2_beat1", 1, {1'b1, 32'h55667788});
    chk("t2_tvalid_idle", po_tvalid, 1'b0);

    // zero-length header, then next byte starts a new header
    beats.delete();
    send_byte(8'h00); send_byte(8'h00);
    chk("t3_busy_zero", po_busy, 1'b0);
    send_byte(8'hAA);
    chk("t3_busy_aa", po_busy, 1'b1);
    idle(3);
    chk("t3_nbeats", beats.size(), 0);
    chk("t3_tvalid", po_tvalid, 1'b0);
    do_reset();

    // 5 words into a 4-deep FIFO with sink stalled
    beats.delete();
    pi_tready = 1'b0;
    send_byte(8'h05); send_byte(8'h00);
    for (int k = 0; k < 20; k++) send_byte(8'(8'h01 + k));
    idle(2);
    chk("t4_tvalid", po_tvalid, 1'b1);
    chk("t4_tdata_head", po_tdata, 32'h01020304);
    chk("t4_tlast_head", po_tlast, 1'b0);
    chk("t4_overflow", po_overflow, 1'b1);
    chk("t4_busy", po_busy, 1'b0);
    chk("t4_nbeats_stall", beats.size(), 0);
    pi_tready = 1'b1;
    idle(8);
    chk("t4_nbeats", beats.size(), 4);
    chk_beat("t4_beat0", 0, {1'b0, 32'h01020304});
    chk_beat("t4_beat1", 1, {1'b0, 32'h05060708});
    chk_beat("t4_beat2", 2, {1'b0, 32'h090A0B0C});
    chk_beat("t4_beat3", 3, {1'b0, 32'h0D0E0F10});
    chk("t4_overflow_sticky", po_overflow, 1'b1);
    do_reset();
    chk("t4_overflow_clr", po_overflow, 1'b0);

    // full FIFO: push of word 5 coincides with a pop
    beats.delete();
    pi_tready = 1'b0;
    send_byte(8'h06); send_byte(8'h00);
    for (int k = 0; k < 19; k++) send_byte(8'(8'h80 + k));
    @(negedge pi_clk);
    pi_rx_data  = 8'h93;
    pi_rx_valid = 1'b1;
    pi_tready   = 1'b1;
    @(negedge pi_clk);
    pi_rx_valid = 1'b0;
    pi_tready   = 1'b0;
    chk("t5_overflow_mid", po_overflow, 1'b0);
    pi_tready = 1'b1;
    for (int k = 20; k < 24; k++) send_byte(8'(8'h80 + k));
    idle(8);
    chk("t5_overflow", po_overflow, 1'b0);
    chk("t5_nbeats", beats.size(), 6);
    for (int j = 0; j < 6; j++)
      chk_beat($sformatf("t5_beat%0d", j), j,
               {(j == 5), 8'(8'h80 + 4*j), 8'(8'h81 + 4*j), 8'(8'h82 + 4*j), 8'(8'h83 + 4*j)});

    // reset mid-packet with one word buffered
    do_reset();
    beats.delete();
    pi_tready = 1'b0;
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    send_byte(8'hB1); send_byte(8'hB2);
    chk("t6_tvalid_pre", po_tvalid, 1'b1);
    chk("t6_busy_pre", po_busy, 1'b1);
    @(negedge pi_clk);
    pi_rst = 1'b1;
    @(negedge pi_clk);
    pi_rst = 1'b0;
    chk("t6_tvalid_rst", po_tvalid, 1'b0);
    chk("t6_busy_rst", po_busy, 1'b0);
    chk("t6_tdata_rst", po_tdata, 32'h0);
    pi_tready = 1'b1;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
    idle(4);
    chk("t6_nbeats", beats.size(), 1);
    chk_beat("t6_beat0", 0, {1'b1, 32'hCAFEBABE});
    chk("t6_busy_end", po_busy, 1'b0);

`ifdef UART_PKT_TIMEOUT_EN
    // stalled payload closed by timeout
    begin
      int cyc;
      do_reset();
      beats.delete();
      pi_tready = 1'b1;
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hDE); send_byte(8'hAD);
      cyc = -1;
      for (int i = 0; i < 200 && cyc < 0; i++) begin
        @(negedge pi_clk);
        if (po_timeout) cyc = i + 1;
      end
      chk("t7_tmo_cycles", cyc, 50);
      chk("t7_tvalid", po_tvalid, 1'b1);
      chk("t7_tdata", po_tdata, 32'hDEAD0000);
      chk("t7_tlast", po_tlast, 1'b1);
      chk("t7_busy", po_busy, 1'b0);
      @(negedge pi_clk);
      chk("t7_tmo_pulse", po_timeout, 1'b0);
      idle(2);
      chk("t7_nbeats", beats.size(), 1);
    end
`else
    // without the timeout build a stalled packet just waits
    do_reset();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hDE);
    idle(120);
    chk("t7_no_tmo", po_timeout, 1'b0);
    chk("t7_still_busy", po_busy, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart2axis_pkt_ctrl.md
Name: uart2axis_pkt_ctrl

Overview:
Packet controller between the UART byte receiver and the AXI-Stream slave interface. It parses a 2-byte length header from the UART byte stream and packs the payload bytes into 32-bit words, first byte in the MSB. The words are buffered in a small word FIFO and presented as AXI-Stream with tlast on the final word. Sticky status flags report overflow, and an optional inter-byte timeout closes stalled packets.

Parameters:
OUT_DEPTH, 4, word FIFO depth; power of 2, minimum 2.
TIMEOUT_CYCLES, 100000, inter-byte gap in clocks that aborts a packet (used only with the optional feature).

Ports:
pi_clk  in  1  clock
pi_rst  in  1  synchronous reset, active-high
pi_rx_data  in  8  received UART byte
pi_rx_valid  in  1  one-cycle strobe; pi_rx_data is valid in this cycle
po_tdata  out  32  AXI-Stream data
po_tvalid  out  1  AXI-Stream valid
pi_tready  in  1  AXI-Stream ready
po_tlast  out  1  last word of the packet
po_busy  out  1  high in any state other than IDLE
po_overflow  out  1  sticky: a word was dropped because the FIFO was full
po_timeout  out  1  one-cycle pulse when a packet is aborted by timeout

Behaviour:
- Reset (pi_rst=1 at a clock edge):
  - state=IDLE; FIFO emptied; byte index=0; word counter=0.
  - All outputs are 0 from the following cycle.
  - Reset mid-packet discards all partial and buffered data.
- FSM states:
  - IDLE: a byte latches len[7:0], then go to LEN_HI.
  - LEN_HI: a byte latches len[15:8].
    - len=0: return to IDLE; nothing is emitted.
    - len>0: load words_left=len, go to PAYLOAD.
  - PAYLOAD: bytes fill the shift register in order: byte0 -> [31:24], byte1 -> [23:16], byte2 -> [15:8], byte3 -> [7:0].
    - On the 4th byte, push {word, last=(words_left==1)} and decrement words_left.
    - Pushing the last word returns the FSM to IDLE in the same edge.
- Length is counted in words (1..65535). Payload is always a whole number of words.
- Word FIFO:
  - Entries are 33 bits (data + last). Head drives po_tdata/po_tlast directly; po_tvalid = not empty.
  - Pop on po_tvalid && pi_tready.
  - Push on the 4th-byte strobe.
  - Latency: 4th byte strobe at edge N with the FIFO empty gives po_tvalid=1 from cycle N+1.
- Simultaneous push and pop when full: both are accepted and the count is unchanged.
- Push when full with no pop:
  - The word is dropped and po_overflow is set (cleared only by reset).
  - words_left still decrements and the FSM proceeds normally. A dropped last word means that packet's tlast is lost.
- po_tdata/po_tlast stay stable while po_tvalid=1 and pi_tready=0.
- Bytes arriving in IDLE are always treated as a header. Nothing is ever ignored except via reset.
- pi_rx_valid is guaranteed at most once every 2 cycles, so no back-to-back byte handling is required.

Optional Feature:
UART_PKT_TIMEOUT_EN
- Defined:
  - A gap counter clears on every pi_rx_valid and counts in LEN_HI and PAYLOAD.
  - On reaching TIMEOUT_CYCLES in LEN_HI: go to IDLE and pulse po_timeout.
  - On reaching TIMEOUT_CYCLES in PAYLOAD: push one word with last=1 and go to IDLE, pulsing po_timeout.
    - The word holds the partial bytes, zero-padded in the low bytes.
    - If the byte index is 0, the word is 32'h0.
  - This push obeys the same full/overflow rules as a normal push.
- Not defined:
  - No gap counter is built; the FSM waits indefinitely.
  - po_timeout is tied to 0 and TIMEOUT_CYCLES is unused.

Test Plan:
- Bytes 02 00 11 22 33 44 55 66 77 88, pi_tready=1 -> two beats: 32'h11223344 tlast=0, then 32'h55667788 tlast=1; po_busy falls after the 10th byte.
- Header 00 00, then byte AA -> no output beat; AA is taken as len[7:0] of a new header; po_busy=1.
- pi_tready=0, 5-word packet, OUT_DEPTH=4 -> first 4 words held stable; 5th (last) word dropped; po_overflow=1; raising pi_tready drains 4 beats with no tlast.
- Full FIFO with a pop in the same cycle as a push -> no drop, po_overflow stays 0, word order preserved.
- With UART_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=50: header 01 00, bytes DE AD, then silence -> after 50 cycles one beat 32'hDEAD0000 tlast=1, one-cycle po_timeout, state IDLE.
- pi_rst=1 asserted after 2 payload bytes with 1 word buffered -> po_tvalid=0 and po_busy=0 next cycle; a fresh packet then works normally.
